// File: rtl/shift_seq_ctrl_pkg.sv
// Shared op codes, mode-line encodings and FSM state encodings for the shift sequencer.
package shift_ctrl_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_SHR     = 3'd2;
    localparam logic [2:0] OP_SHL     = 3'd3;
    localparam logic [2:0] OP_ROR     = 3'd4;
    localparam logic [2:0] OP_ROL     = 3'd5;
    localparam logic [2:0] OP_JOHNSON = 3'd6;
    localparam logic [2:0] OP_CLEAR   = 3'd7;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/shift_reg4.sv
// 4-bit universal shift register: hold, shift right (SR into Q[3]), shift left (SL into Q[0]), parallel load.
// Single-cycle update on every clk edge; no backpressure.
module shift_reg4 (
    input  logic       clk,
    input  logic       clr,
    input  logic       M1,
    input  logic       M0,
    input  logic       SR,
    input  logic       SL,
    input  logic [3:0] D,
    output logic [3:0] Q
);

    logic [3:0] q_d;
    logic [3:0] q_q;

    always_comb begin
        q_d = q_q;
        case ({M1, M0})
            2'b01:   q_d = {SR, q_q[3:1]};
            2'b10:   q_d = {q_q[2:0], SL};
            2'b11:   q_d = D;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) q_q <= 4'b0000;
        else      q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving a 4-bit universal shift register for exactly N clocks per command.
// Latency: accept edge, N RUN clocks, one DONE cycle; cmd_ready only in IDLE, commands are never queued.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [3:0]       cmd_data,
    input  logic [3:0]       q_in,
    output logic             M1,
    output logic             M0,
    output logic             SR,
    output logic             SL,
    output logic [3:0]       D,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [2:0]       op_d, op_q;
    logic [3:0]       data_d, data_q;
    logic [CNT_W-1:0] eff_cnt;
    logic [1:0]       mode;
    logic             unused_q;

    // Only the end bits of Q feed the rotate/Johnson serial inputs.
    assign unused_q = ^q_in[2:1];

    always_comb begin
        case (cmd_op)
            OP_NOP:            eff_cnt = '0;
            OP_LOAD, OP_CLEAR: eff_cnt = CNT_W'(1);
            default:           eff_cnt = cmd_cnt;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    cnt_d   = eff_cnt;
                    state_d = (eff_cnt == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            data_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    // Serial bits for rotate/Johnson come from live Q, so multi-clock rotates need no shadow copy.
    always_comb begin
        mode = MODE_HOLD;
        SR   = 1'b0;
        SL   = 1'b0;
        D    = 4'b0000;
        if (state_q == ST_RUN) begin
            case (op_q)
                OP_LOAD:    begin mode = MODE_LOAD; D  = data_q;    end
                OP_SHR:     begin mode = MODE_SHR;  SR = data_q[0]; end
                OP_SHL:     begin mode = MODE_SHL;  SL = data_q[0]; end
                OP_ROR:     begin mode = MODE_SHR;  SR = q_in[0];   end
                OP_ROL:     begin mode = MODE_SHL;  SL = q_in[3];   end
                OP_JOHNSON: begin mode = MODE_SHR;  SR = ~q_in[0];  end
                OP_CLEAR:   begin mode = MODE_LOAD; D  = 4'b0000;   end
                default:    mode = MODE_HOLD;
            endcase
        end
    end

    assign M1        = mode[1];
    assign M0        = mode[0];
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign cmd_ready = (state_q == ST_IDLE) && clr;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl driving shift_reg4; hand-computed Q sequences and handshake timing.
module tb_shift_seq_ctrl;
    import shift_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_cnt = 4'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [3:0] q;
    logic       M1, M0, SR, SL, busy, done;
    logic [3:0] D;

    int n_checks = 0;
    int n_fail   = 0;

    shift_seq_ctrl #(.CNT_W(4)) u_ctrl (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .q_in(q),
        .M1(M1), .M0(M0), .SR(SR), .SL(SL), .D(D), .busy(busy), .done(done)
    );

    shift_reg4 u_reg (
        .clk(clk), .clr(clr), .M1(M1), .M0(M0), .SR(SR), .SL(SL), .D(D), .Q(q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a command at a negedge, waits for acceptance, and returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] cnt, input logic [3:0] data);
        int k;
        @(negedge clk);
        cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) chk("accept_timeout", 32'(k), 32'd0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Checks Q after each of n shifts, then the DONE cycle.
    task automatic run_seq(input string tag, input int n, input logic [3:0] exp_q [16]);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            chk({tag, "_q"}, 32'(q), 32'(exp_q[i]));
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_mode_hold"}, 32'({M1, M0}), 32'd0);
    endtask

    initial begin
        logic [3:0] seq [16];
        int k;

        // Reset
        #12;
        chk("rst_mode", 32'({M1, M0}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(D), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // LOAD 1010
        issue(OP_LOAD, 4'd0, 4'b1010);
        chk("load_mode", 32'({M1, M0}), 32'b11);
        chk("load_d", 32'(D), 32'b1010);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("load_q", 32'(q), 32'b1010);
        chk("load_done", 32'(done), 32'd1);
        chk("load_busy2", 32'(busy), 32'd1);
        chk("load_d_after", 32'(D), 32'd0);
        @(negedge clk);
        chk("load_done_clr", 32'(done), 32'd0);
        chk("load_ready", 32'(cmd_ready), 32'd1);

        // LOAD 1000, ROR 2, ROL 3
        issue(OP_LOAD, 4'd0, 4'b1000);
        @(negedge clk);
        chk("load2_q", 32'(q), 32'b1000);
        issue(OP_ROR, 4'd2, 4'b0000);
        seq[0] = 4'b0100; seq[1] = 4'b0010;
        run_seq("ror", 2, seq);
        issue(OP_ROL, 4'd3, 4'b0000);
        seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0001;
        run_seq("rol", 3, seq);

        // CLEAR then Johnson 8
        issue(OP_CLEAR, 4'd5, 4'b1111);
        chk("clear_mode", 32'({M1, M0}), 32'b11);
        chk("clear_d", 32'(D), 32'd0);
        @(negedge clk);
        chk("clear_q", 32'(q), 32'd0);
        issue(OP_JOHNSON, 4'd8, 4'b0000);
        seq[0] = 4'b1000; seq[1] = 4'b1100; seq[2] = 4'b1110; seq[3] = 4'b1111;
        seq[4] = 4'b0111; seq[5] = 4'b0011; seq[6] = 4'b0001; seq[7] = 4'b0000;
        run_seq("john", 8, seq);
        @(negedge clk);
        chk("john_mode_after", 32'({M1, M0}), 32'd0);

        // Zero-count commands
        issue(OP_LOAD, 4'd0, 4'b0110);
        @(negedge clk);
        issue(OP_SHL, 4'd0, 4'b0001);
        chk("shl0_done", 32'(done), 32'd1);
        chk("shl0_mode", 32'({M1, M0}), 32'd0);
        chk("shl0_q", 32'(q), 32'b0110);
        issue(OP_NOP, 4'd9, 4'b1111);
        chk("nop_done", 32'(done), 32'd1);
        chk("nop_mode", 32'({M1, M0}), 32'd0);
        chk("nop_q", 32'(q), 32'b0110);

        // cmd_valid held while busy is taken only after DONE
        @(negedge clk);
        cmd_op = OP_SHR; cmd_cnt = 4'd1; cmd_data = 4'b0001; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_op = OP_NOP;
        chk("hold_ready_run", 32'(cmd_ready), 32'd0);
        chk("hold_mode_run", 32'({M1, M0}), 32'b01);
        @(negedge clk);
        chk("hold_q", 32'(q), 32'b1011);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_ready_done", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("hold_ready_idle", 32'(cmd_ready), 32'd1);
        chk("hold_idle_done", 32'(done), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("hold_nop_done", 32'(done), 32'd1);
        chk("hold_nop_q", 32'(q), 32'b1011);

        // SHR 15 with fill 1, aborted by clr during the 5th shift
        issue(OP_SHR, 4'd15, 4'b0001);
        seq[0] = 4'b1101; seq[1] = 4'b1110; seq[2] = 4'b1111; seq[3] = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("shr_q", 32'(q), 32'(seq[i]));
        end
        @(negedge clk);
        chk("shr5_mode", 32'({M1, M0}), 32'b01);
        clr = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mode", 32'({M1, M0}), 32'd0);
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_sr", 32'(SR), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        chk("abort_ready", 32'(cmd_ready), 32'd1);

        // LOAD 0101 after abort
        issue(OP_LOAD, 4'd0, 4'b0101);
        chk("reload_mode", 32'({M1, M0}), 32'b11);
        @(negedge clk);
        chk("reload_q", 32'(q), 32'b0101);
        chk("reload_done", 32'(done), 32'd1);

        // SHL all-ones count: 15 shifts, no counter wrap
        issue(OP_SHL, 4'd15, 4'b0000);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("shl15_cycles", 32'(k), 32'd15);
        chk("shl15_q", 32'(q), 32'd0);
        @(negedge clk);
        chk("shl15_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
